// File: rtl/tcs_init_sequencer_pkg.sv
// Shared constants, state codes and the write-command payload for the
// TCS3472 power-up register-write sequencer.
package tcs_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h29;

    localparam logic [7:0] REG_ENABLE  = 8'h00;
    localparam logic [7:0] REG_ATIME   = 8'h01;
    localparam logic [7:0] REG_CONTROL = 8'h0F;
    localparam logic [7:0] CMD_BIT     = 8'h80;
    localparam logic [7:0] EN_PON      = 8'h01;
    localparam logic [7:0] EN_AEN      = 8'h02;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_PWRUP_WAIT = 3'd0;
    localparam state_t ST_LOAD       = 3'd1;
    localparam state_t ST_REQ        = 3'd2;
    localparam state_t ST_WAIT_DONE  = 3'd3;
    localparam state_t ST_WAIT_IDLE  = 3'd4;
    localparam state_t ST_PON_WAIT   = 3'd5;
    localparam state_t ST_READY      = 3'd6;
    localparam state_t ST_ERROR      = 3'd7;

    // One register write as handed to the I2C write master.
    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } wr_cmd_t;

    // TCS3472 command byte: command bit set, register address in the low bits.
    function automatic logic [7:0] cmd_byte(input logic [7:0] reg_addr);
        return CMD_BIT | reg_addr;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tcs_init_sequencer_rom.sv
// Fixed four-step sensor bring-up script: step index to {command byte, data}.
module tcs_init_rom
    import tcs_pkg::*;
#(
    parameter logic [7:0] ATIME_VAL = 8'hF6,
    parameter logic [7:0] GAIN_VAL  = 8'h01
) (
    input  logic [1:0] step_idx_i,
    output wr_cmd_t    cmd_c_o
);

    always_comb begin
        cmd_c_o = '0;
        case (step_idx_i)
            2'd0: begin
                cmd_c_o.reg_addr = cmd_byte(REG_ATIME);
                cmd_c_o.data     = ATIME_VAL;
            end
            2'd1: begin
                cmd_c_o.reg_addr = cmd_byte(REG_CONTROL);
                cmd_c_o.data     = GAIN_VAL;
            end
            2'd2: begin
                cmd_c_o.reg_addr = cmd_byte(REG_ENABLE);
                cmd_c_o.data     = EN_PON;
            end
            2'd3: begin
                cmd_c_o.reg_addr = cmd_byte(REG_ENABLE);
                cmd_c_o.data     = EN_PON | EN_AEN;
            end
            default: cmd_c_o = '0;
        endcase
    end

endmodule

// File: rtl/tcs_init_sequencer.sv
// Brings the TCS3472 colour sensor out of power-up by driving the I2C write
// master through a fixed register script, then flags ready or a stalled write.
module tcs_init_sequencer
    import tcs_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = DEV_ADDR_DEFAULT,
    parameter logic [7:0]  ATIME_VAL      = 8'hF6,
    parameter logic [7:0]  GAIN_VAL       = 8'h01,
    parameter int unsigned PWRUP_CYCLES   = 250000,
    parameter int unsigned PON_CYCLES     = 75000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    output logic       wr_start,
    output logic [6:0] wr_dev_addr,
    output logic [7:0] wr_reg_addr,
    output logic [7:0] wr_data,
    input  logic       wr_busy,
    input  logic       wr_done,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] step_idx
);

    localparam int unsigned CNT_MAX = max3(PWRUP_CYCLES, PON_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PON_LAST   = CNT_W'(PON_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             start_q, start_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    wr_cmd_t rom_cmd_c;
    logic    step_active_c;
    logic    tmo_expired_c;

    tcs_init_rom #(
        .ATIME_VAL (ATIME_VAL),
        .GAIN_VAL  (GAIN_VAL)
    ) u_rom (
        .step_idx_i (step_q),
        .cmd_c_o    (rom_cmd_c)
    );

    // One timeout budget spans every phase of a single write step.
    assign step_active_c = (state_q == ST_LOAD)      || (state_q == ST_REQ) ||
                           (state_q == ST_WAIT_DONE) || (state_q == ST_WAIT_IDLE);
    assign tmo_expired_c = step_active_c && (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dly_d      = dly_q;
        tmo_d      = tmo_q;
        start_d    = start_q;
        dev_d      = DEV_ADDR;
        reg_addr_d = reg_addr_q;
        data_d     = data_q;
        done_d     = done_q;
        error_d    = error_q;

        if (step_active_c) begin
            tmo_d = tmo_q + CNT_ONE;
        end

        case (state_q)
            ST_PWRUP_WAIT: begin
                if (dly_q == PWRUP_LAST) begin
                    state_d = ST_LOAD;
                    dly_d   = '0;
                    tmo_d   = '0;
                end else begin
                    dly_d = dly_q + CNT_ONE;
                end
            end
            // A stale transaction keeps busy high; hold off the start until it clears.
            ST_LOAD: begin
                reg_addr_d = rom_cmd_c.reg_addr;
                data_d     = rom_cmd_c.data;
                if (!wr_busy) begin
                    state_d = ST_REQ;
                    start_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (wr_busy) begin
                    state_d = ST_WAIT_DONE;
                    start_d = 1'b0;
                end
            end
            ST_WAIT_DONE: begin
                if (wr_done) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!wr_busy) begin
                    if (step_q == 2'd2) begin
                        state_d = ST_PON_WAIT;
                        dly_d   = '0;
                    end else if (step_q == 2'd3) begin
                        state_d = ST_READY;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        step_d  = step_q + 2'd1;
                        tmo_d   = '0;
                    end
                end
            end
            // Oscillator settling after PON before integration may be enabled.
            ST_PON_WAIT: begin
                if (dly_q == PON_LAST) begin
                    state_d = ST_LOAD;
                    step_d  = 2'd3;
                    dly_d   = '0;
                    tmo_d   = '0;
                end else begin
                    dly_d = dly_q + CNT_ONE;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_d = ST_LOAD;
                    done_d  = 1'b0;
                    step_d  = 2'd0;
                    tmo_d   = '0;
                end
            end
            ST_ERROR: begin
                start_d = 1'b0;
                if (init_req) begin
                    state_d = ST_LOAD;
                    error_d = 1'b0;
                    step_d  = 2'd0;
                    tmo_d   = '0;
                end
            end
            default: begin
                state_d = ST_PWRUP_WAIT;
            end
        endcase

        // Stalled step: abandon it and keep step_idx pointing at the culprit.
        if (tmo_expired_c) begin
            state_d = ST_ERROR;
            step_d  = step_q;
            start_d = 1'b0;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PWRUP_WAIT;
            step_q     <= 2'd0;
            dly_q      <= '0;
            tmo_q      <= '0;
            start_q    <= 1'b0;
            dev_q      <= DEV_ADDR;
            reg_addr_q <= 8'h00;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            dly_q      <= dly_d;
            tmo_q      <= tmo_d;
            start_q    <= start_d;
            dev_q      <= dev_d;
            reg_addr_q <= reg_addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign wr_start    = start_q;
    assign wr_dev_addr = dev_q;
    assign wr_reg_addr = reg_addr_q;
    assign wr_data     = data_q;
    assign init_done   = done_q;
    assign init_error  = error_q;
    assign step_idx    = step_q;

endmodule

// File: tb/tb_tcs_init_sequencer.sv
// Bench for tcs_init_sequencer: a randomized write-master model plus a
// timing/script reference built from the sensor bring-up rules.
module tb_tcs_init_sequencer;

    localparam int unsigned PWRUP = 20;
    localparam int unsigned PON   = 10;
    localparam int unsigned TMO   = 500;
    localparam logic [6:0]  DEV   = 7'h29;
    localparam logic [7:0]  ATIME = 8'hF6;
    localparam logic [7:0]  GAIN  = 8'h01;

    logic       clk;
    logic       rst;
    logic       init_req;
    logic       wr_start;
    logic [6:0] wr_dev_addr;
    logic [7:0] wr_reg_addr;
    logic [7:0] wr_data;
    logic       wr_busy;
    logic       wr_done;
    logic       init_done;
    logic       init_error;
    logic [1:0] step_idx;

    tcs_init_sequencer #(
        .DEV_ADDR       (DEV),
        .ATIME_VAL      (ATIME),
        .GAIN_VAL       (GAIN),
        .PWRUP_CYCLES   (PWRUP),
        .PON_CYCLES     (PON),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_req    (init_req),
        .wr_start    (wr_start),
        .wr_dev_addr (wr_dev_addr),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .wr_busy     (wr_busy),
        .wr_done     (wr_done),
        .init_done   (init_done),
        .init_error  (init_error),
        .step_idx    (step_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference expectations shared between the master model and the sequence.
    int exp_step  = 0;
    int exp_start = -1;
    int exp_done  = -1;
    int last_start = 0;
    int n_caps    = 0;

    // Master-model knobs and state.
    int   force_dly = 0;
    bit   no_done   = 1'b0;
    bit   m_abort   = 1'b0;
    int   m_phase   = 0;
    int   m_cnt     = 0;
    int   m_work    = 0;
    int   m_dlen    = 0;
    int   m_step    = 0;
    bit   m_nodone  = 1'b0;
    bit   m_first   = 1'b0;
    logic [22:0] m_cmd;

    logic [15:0] script [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [22:0] exp_cmd(input int s);
        if (s >= 0 && s < 4) return {DEV, script[s]};
        return '1;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Write master: busy a random delay after start, then work, done, idle.
    initial begin
        wr_busy = 1'b0;
        wr_done = 1'b0;
        m_cmd   = '0;
        forever begin
            @(posedge clk); #1;
            if (rst || m_abort) begin
                wr_busy = 1'b0;
                wr_done = 1'b0;
                m_phase = 0;
                m_abort = 1'b0;
            end else begin
                case (m_phase)
                    0: if (wr_start) begin
                        check("start_cycle", 32'(cyc), 32'(exp_start));
                        check("write_cmd", 32'({wr_dev_addr, wr_reg_addr, wr_data}), 32'(exp_cmd(exp_step)));
                        check("start_step_idx", 32'(step_idx), 32'(exp_step));
                        m_cmd      = {wr_dev_addr, wr_reg_addr, wr_data};
                        m_step     = exp_step;
                        exp_step   = exp_step + 1;
                        n_caps     = n_caps + 1;
                        last_start = cyc;
                        m_cnt      = (force_dly != 0) ? force_dly : int'($urandom_range(1, 4));
                        m_work     = int'($urandom_range(0, 3));
                        m_dlen     = int'($urandom_range(1, 3));
                        m_nodone   = no_done;
                        m_phase    = 1;
                    end
                    1: begin
                        check("start_held", 32'(wr_start), 32'd1);
                        check("cmd_stable", 32'({wr_dev_addr, wr_reg_addr, wr_data}), 32'(m_cmd));
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            wr_busy = 1'b1;
                            m_cnt   = m_work;
                            m_first = 1'b1;
                            m_phase = 2;
                        end
                    end
                    2: begin
                        if (m_first) check("start_drop", 32'(wr_start), 32'd0);
                        m_first = 1'b0;
                        check("cmd_stable", 32'({wr_dev_addr, wr_reg_addr, wr_data}), 32'(m_cmd));
                        if (!m_nodone) begin
                            if (m_cnt == 0) begin
                                wr_done = 1'b1;
                                m_cnt   = m_dlen;
                                m_phase = 3;
                            end else begin
                                m_cnt = m_cnt - 1;
                            end
                        end
                    end
                    default: begin
                        check("cmd_stable", 32'({wr_dev_addr, wr_reg_addr, wr_data}), 32'(m_cmd));
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            wr_done = 1'b0;
                            wr_busy = 1'b0;
                            m_phase = 0;
                            if (m_step == 3) exp_done = cyc + 1;
                            else if (m_step == 2) exp_start = cyc + int'(PON) + 2;
                            else exp_start = cyc + 2;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic pulse_req(input bit honored);
        @(negedge clk);
        init_req = 1'b1;
        if (honored) begin
            exp_start = cyc + 2;
            exp_step  = 0;
        end
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst       = 1'b0;
        exp_start = cyc + int'(PWRUP) + 1;
        exp_step  = 0;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        check({tag, "_wr_start"}, 32'(wr_start), 32'd0);
        check({tag, "_step_idx"}, 32'(step_idx), 32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_reg_addr"}, 32'(wr_reg_addr), 32'd0);
        release_rst();
    endtask

    task automatic wait_caps(input int target, input string tag);
        int n = 0;
        while (n_caps < target && n < 3000) begin tick(); n++; end
        if (n_caps < target) check({tag, "_writes_timeout"}, 32'(n_caps), 32'(target));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (init_done !== 1'b1 && n < 3000) begin tick(); n++; end
        if (init_done !== 1'b1) begin
            check({tag, "_done_timeout"}, 32'(init_done), 32'd1);
        end else begin
            check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
            check({tag, "_step_idx"}, 32'(step_idx), 32'd3);
            check({tag, "_init_error"}, 32'(init_error), 32'd0);
            check({tag, "_wr_start"}, 32'(wr_start), 32'd0);
        end
    endtask

    initial begin
        int base;
        int n;
        script[0] = {8'h81, ATIME};
        script[1] = {8'h8F, GAIN};
        script[2] = {8'h80, 8'h01};
        script[3] = {8'h80, 8'h03};
        rst      = 1'b1;
        init_req = 1'b0;

        repeat (3) tick();
        check("rst_wr_start", 32'(wr_start), 32'd0);
        check("rst_dev_addr", 32'(wr_dev_addr), 32'(DEV));
        check("rst_reg_addr", 32'(wr_reg_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_init_error", 32'(init_error), 32'd0);
        check("rst_step_idx", 32'(step_idx), 32'd0);

        release_rst();
        wait_done("run0");
        check("run0_writes", 32'(n_caps), 32'd4);

        // Replays from READY; first with slow busy, one with an ignored mid-script request.
        for (int r = 0; r < 4; r++) begin
            force_dly = (r == 0) ? 7 : 0;
            pulse_req(1'b1);
            base = n_caps;
            if (r == 1) begin
                wait_caps(base + 3, "ign_req");
                pulse_req(1'b0);
            end
            wait_done("replay");
            check("replay_writes", 32'(n_caps), 32'(base + 4));
            force_dly = 0;
        end

        // Stall step 1 so its write never completes.
        pulse_req(1'b1);
        base = n_caps;
        wait_caps(base + 1, "tmo_s0");
        no_done = 1'b1;
        wait_caps(base + 2, "tmo_s1");
        no_done = 1'b0;
        n = 0;
        while (init_error !== 1'b1 && n < 3000) begin tick(); n++; end
        if (init_error !== 1'b1) begin
            check("tmo_error_timeout", 32'(init_error), 32'd1);
        end else begin
            check("tmo_error_cycle", 32'(cyc), 32'(last_start + int'(TMO) - 1));
            check("tmo_step_idx", 32'(step_idx), 32'd1);
            check("tmo_wr_start", 32'(wr_start), 32'd0);
            check("tmo_init_done", 32'(init_done), 32'd0);
        end
        m_abort = 1'b1;
        tick();
        tick();
        check("err_hold", 32'(init_error), 32'd1);
        pulse_req(1'b1);
        tick();
        check("recover_error_clr", 32'(init_error), 32'd0);
        wait_done("recover");
        check("recover_writes", 32'(n_caps), 32'(base + 6));

        // Reset while step 1 sits waiting for done; power-up wait must restart.
        pulse_req(1'b1);
        base = n_caps;
        wait_caps(base + 1, "mr_s0");
        no_done = 1'b1;
        wait_caps(base + 2, "mr_s1");
        no_done = 1'b0;
        n = 0;
        while (wr_busy !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        tick();
        check("mr_pre_step_idx", 32'(step_idx), 32'd1);
        reset_pulse("rst_wait_done");
        repeat (5) tick();
        pulse_req(1'b0);
        wait_done("after_rst");

        // Reset while start is held waiting for busy.
        force_dly = 7;
        pulse_req(1'b1);
        n = 0;
        while (wr_start !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        tick();
        check("req_start_pre_rst", 32'(wr_start), 32'd1);
        reset_pulse("rst_req");
        force_dly = 0;
        wait_done("after_rst_req");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
